// File: rtl/xor_template_bank.sv
//==============================================================================
// Module      : xor_template_bank
// Description : Captures one binary corner window per frame and XOR-scores it
//               against NUM_KERNELS 1-bit templates, reporting the best match.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module xor_template_bank #(
    parameter int CORNER_W    = 28,
    parameter int CORNER_H    = 40,
    parameter int X_OFFSET    = 4,
    parameter int NUM_KERNELS = 13,
    parameter int THRESHOLD   = 200,
    localparam int SIZE       = CORNER_W * CORNER_H,
    localparam int SCORE_W    = $clog2(SIZE + 1),
    localparam int IDX_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
    // Kernel k occupies bits [k*SIZE +: SIZE], pixel p of the window at bit p.
    parameter logic [NUM_KERNELS*SIZE-1:0] KERNELS = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [10:0]                  hcount,
    input  logic [9:0]                   vcount,
    input  logic                         mask,
    input  logic [10:0]                  left_edge,
    input  logic [9:0]                   top_edge,
    output logic                         busy,
    output logic                         result_valid,
    output logic [NUM_KERNELS*SCORE_W-1:0] scores,
    output logic [IDX_W-1:0]             best_idx,
    output logic [SCORE_W-1:0]           best_score,
    output logic                         match_ok
);

    localparam int CNT_W = $clog2(SIZE + 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_COMPARE = 3'd2,
        S_SELECT  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                         state_q;
    logic [10:0]                    le_q;
    logic [9:0]                     te_q;
    logic [SCORE_W-1:0]             waddr_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [IDX_W-1:0]               sel_q;
    logic [IDX_W-1:0]               run_idx_q;
    logic [SCORE_W-1:0]             run_score_q;
    logic [1:0]                     vld_q;
    logic [1:0]                     buf_rd_q;
    logic [SIZE-1:0]                buf_q;
    logic                           result_valid_q;
    logic [NUM_KERNELS*SCORE_W-1:0] scores_q;
    logic [IDX_W-1:0]               best_idx_q;
    logic [SCORE_W-1:0]             best_score_q;
    logic                           match_ok_q;

    logic [11:0]                    w_hlo;
    logic [11:0]                    w_hhi;
    logic [10:0]                    w_vlo;
    logic [10:0]                    w_vhi;
    logic                           w_in_win;
    logic                           w_frame_start;
    logic                           w_wr;
    logic                           w_rd_en;
    logic [CNT_W-1:0]               w_raddr;
    logic [SCORE_W-1:0]             w_acc [NUM_KERNELS];
    logic [NUM_KERNELS*SCORE_W-1:0] w_scores;

    // Window bounds are exclusive on the low side, inclusive on the high side.
    assign w_hlo    = {1'b0, le_q} + 12'(X_OFFSET);
    assign w_hhi    = w_hlo + 12'(CORNER_W);
    assign w_vlo    = {1'b0, te_q};
    assign w_vhi    = w_vlo + 11'(CORNER_H);
    assign w_in_win = ({1'b0, hcount} > w_hlo) && ({1'b0, hcount} <= w_hhi) &&
                      ({1'b0, vcount} > w_vlo) && ({1'b0, vcount} <= w_vhi);

    assign w_frame_start = (hcount == 11'd0) && (vcount == 10'd0);
    assign w_wr          = (state_q == S_CAPTURE) && w_in_win && (waddr_q < SCORE_W'(SIZE));
    assign w_rd_en       = (state_q == S_COMPARE) && (cnt_q < CNT_W'(SIZE));
    assign w_raddr       = w_rd_en ? cnt_q : '0;

    assign busy         = (state_q == S_CAPTURE) || (state_q == S_COMPARE) || (state_q == S_SELECT);
    assign result_valid = result_valid_q;
    assign scores       = scores_q;
    assign best_idx     = best_idx_q;
    assign best_score   = best_score_q;
    assign match_ok     = match_ok_q;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            buf_q[waddr_q] <= mask;
        end
    end

    // Two-stage read pipeline shared by the buffer and every kernel ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= 2'b00;
            buf_rd_q <= 2'b00;
        end else begin
            vld_q    <= {vld_q[0], w_rd_en};
            buf_rd_q <= {buf_rd_q[0], (w_rd_en ? buf_q[w_raddr] : 1'b0)};
        end
    end

    for (genvar k = 0; k < NUM_KERNELS; k++) begin : g_kernel
        logic               rd1_q;
        logic               rd2_q;
        logic [SCORE_W-1:0] acc_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd1_q <= 1'b0;
                rd2_q <= 1'b0;
                acc_q <= '0;
            end else begin
                rd1_q <= w_rd_en ? KERNELS[k*SIZE + int'(w_raddr)] : 1'b0;
                rd2_q <= rd1_q;
                if ((state_q == S_IDLE) || (state_q == S_CAPTURE)) begin
                    acc_q <= '0;
                end else if ((state_q == S_COMPARE) && vld_q[1]) begin
                    acc_q <= acc_q + SCORE_W'(buf_rd_q[1] ^ rd2_q);
                end
            end
        end

        assign w_acc[k]                         = acc_q;
        assign w_scores[k*SCORE_W +: SCORE_W] = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            le_q           <= '0;
            te_q           <= '0;
            waddr_q        <= '0;
            cnt_q          <= '0;
            sel_q          <= '0;
            run_idx_q      <= '0;
            run_score_q    <= '0;
            result_valid_q <= 1'b0;
            scores_q       <= '0;
            best_idx_q     <= '0;
            best_score_q   <= '0;
            match_ok_q     <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_frame_start) begin
                        le_q    <= left_edge;
                        te_q    <= top_edge;
                        waddr_q <= '0;
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (waddr_q == SCORE_W'(SIZE)) begin
                        cnt_q   <= '0;
                        state_q <= S_COMPARE;
                    end else if (w_frame_start) begin
                        state_q <= S_IDLE;
                    end else if (w_wr) begin
                        waddr_q <= waddr_q + 1'b1;
                    end
                end
                S_COMPARE: begin
                    // Two extra cycles drain the read pipeline into the accumulators.
                    if (cnt_q == CNT_W'(SIZE + 1)) begin
                        sel_q   <= '0;
                        state_q <= S_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SELECT: begin
                    if ((sel_q == '0) || (w_acc[sel_q] < run_score_q)) begin
                        run_score_q <= w_acc[sel_q];
                        run_idx_q   <= sel_q;
                    end
                    if (sel_q == IDX_W'(NUM_KERNELS - 1)) begin
                        state_q <= S_DONE;
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                S_DONE: begin
                    scores_q       <= w_scores;
                    best_idx_q     <= run_idx_q;
                    best_score_q   <= run_score_q;
                    match_ok_q     <= (int'(run_score_q) <= THRESHOLD);
                    result_valid_q <= 1'b1;
                    sel_q          <= '0;
                    state_q        <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
